// File: rtl/pipe_skid_if.sv
// pipe_skid_if: valid/ready stage bundle with flush and occupancy, stage-side (slave) and driver-side (master) views.
interface pipe_skid_if #(parameter int WIDTH = 32);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       count;
  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );
  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: pipeline stage register with valid/ready handshake, optional skid entry and synchronous flush.
module pipe_skid_reg #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  parameter bit               SKID    = 1'b1
) (
  input logic       clk,
  input logic       rst,
  pipe_skid_if.slave bus
);
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;
  logic [1:0]       state, nxt;
  logic             vld, rdy, acc, pop, load_main, load_skid;
  logic [WIDTH-1:0] main_q, skid_q;
  // Without a skid entry the stage can only take a beat when the held one leaves this cycle.
  assign bus.in_ready  = SKID ? rdy : (!vld | bus.out_ready);
  assign acc           = bus.in_valid & bus.in_ready;
  assign pop           = vld & bus.out_ready;
  assign bus.out_valid = vld;
  assign bus.out_data  = main_q;
  assign bus.count     = state;
  always_comb begin
    nxt = bus.flush        ? EMPTY :
          (state == EMPTY) ? (acc ? ONE : EMPTY) :
          (state == ONE)   ? ((acc & !pop) ? TWO : (!acc & pop) ? EMPTY : ONE) :
                             (pop ? ONE : TWO);
    load_main = !bus.flush & ((state == TWO) ? pop : (acc & ((state == EMPTY) | pop)));
    load_skid = !bus.flush & (state == ONE) & acc & !pop;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state  <= EMPTY;
      vld    <= 1'b0;
      rdy    <= 1'b1;
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
    end else begin
      state <= nxt;
      vld   <= nxt != EMPTY;
      rdy   <= nxt != TWO;
      if (load_main) main_q <= (state == TWO) ? skid_q : bus.in_data;
      if (load_skid) skid_q <= bus.in_data;
    end
endmodule
